wb_regfile_writer: RTL and testbench



---
 rtl/wb_regfile_writer_pkg.sv | 35 +++
 rtl/wb_regfile_writer_load_align.sv | 31 +++
 rtl/wb_regfile_writer.sv | 136 +++++++++++++
 tb/tb_wb_regfile_writer.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_regfile_writer_pkg.sv
// Shared types and constants for the writeback register-file writer.
package wb_pkg;

    localparam int unsigned WB_NBITS      = 32;
    localparam int unsigned WB_NREGISTERS = 32;
    localparam int unsigned WB_AW         = $clog2(WB_NREGISTERS);

    // Result source select; the unlisted code 2'b11 also selects the ALU.
    typedef enum logic [1:0] {
        SRC_ALU  = 2'b00,
        SRC_LOAD = 2'b01,
        SRC_PC4  = 2'b10
    } src_e;

    // Load funct3 encodings.
    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    // One pending register-file write.
    typedef struct packed {
        logic [WB_AW-1:0]    rd;
        logic [WB_NBITS-1:0] data;
    } wb_entry_t;

    // Occupancy of the 2-entry pending-write FIFO.
    typedef enum logic [1:0] {
        FIFO_EMPTY = 2'd0,
        FIFO_ONE   = 2'd1,
        FIFO_TWO   = 2'd2
    } fifo_state_e;

endpackage

// File: rtl/wb_regfile_writer_load_align.sv
// Extracts and extends the loaded byte/half/word according to funct3 and offset.
module load_align
    import wb_pkg::*;
#(
    parameter int unsigned NBITS = WB_NBITS
) (
    input  logic [NBITS-1:0] word,
    input  logic [2:0]       funct3,
    input  logic [1:0]       addr_lo,
    output logic [NBITS-1:0] result
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Pick the addressed byte/half, then extend it by load type.
    always_comb begin
        byte_sel = word[{addr_lo, 3'b000} +: 8];
        half_sel = word[{addr_lo[1], 4'b0000} +: 16];
        result   = word;
        case (funct3)
            F3_LB:   result = {{(NBITS-8){byte_sel[7]}}, byte_sel};
            F3_LH:   result = {{(NBITS-16){half_sel[15]}}, half_sel};
            F3_LW:   result = word;
            F3_LBU:  result = {{(NBITS-8){1'b0}}, byte_sel};
            F3_LHU:  result = {{(NBITS-16){1'b0}}, half_sel};
            default: result = word;
        endcase
    end

endmodule

// File: rtl/wb_regfile_writer.sv
// Writeback driver of the register file write port with a 2-entry pending
// buffer and forwarding of not-yet-written results to the decode read ports.
module wb_regfile_writer
    import wb_pkg::*;
#(
    parameter int unsigned NBITS      = WB_NBITS,
    parameter int unsigned NREGISTERS = WB_NREGISTERS,
    localparam int unsigned AW        = $clog2(NREGISTERS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [AW-1:0]    in_rd,
    input  logic [1:0]       in_src,
    input  logic [NBITS-1:0] in_alu,
    input  logic [NBITS-1:0] in_mem,
    input  logic [NBITS-1:0] in_pc4,
    input  logic [2:0]       in_funct3,
    input  logic [1:0]       in_addr_lo,
    input  logic             rf_gnt,
    output logic             wr,
    output logic [AW-1:0]    add_wr,
    output logic [NBITS-1:0] datain,
    input  logic [AW-1:0]    q_rd1,
    input  logic [AW-1:0]    q_rd2,
    output logic             fwd1_hit,
    output logic             fwd2_hit,
    output logic [NBITS-1:0] fwd1_data,
    output logic [NBITS-1:0] fwd2_data
);

    fifo_state_e      state, state_nxt;
    wb_entry_t        entry_q [2];
    logic             wr_ptr;
    logic             rd_ptr;
    logic [NBITS-1:0] load_data;
    logic [NBITS-1:0] wb_data;
    logic             accept;
    logic             push;
    logic             pop;
    wb_entry_t        head;
    wb_entry_t        young;
    wb_entry_t        old;
    logic             young_v;
    logic             old_v;

    load_align #(.NBITS(NBITS)) u_load_align (
        .word    (in_mem),
        .funct3  (in_funct3),
        .addr_lo (in_addr_lo),
        .result  (load_data)
    );

    // Select the writeback value by source.
    always_comb begin
        wb_data = in_alu;
        case (in_src)
            SRC_LOAD: wb_data = load_data;
            SRC_PC4:  wb_data = in_pc4;
            default:  wb_data = in_alu;
        endcase
    end

    assign in_ready = !rst && (state != FIFO_TWO);
    assign accept   = in_valid && in_ready;
    assign push     = accept && (in_rd != '0);
    assign pop      = wr && rf_gnt;

    // FIFO occupancy, storage and pointers; reset discards pending writes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= FIFO_EMPTY;
            wr_ptr     <= 1'b0;
            rd_ptr     <= 1'b0;
            entry_q[0] <= '0;
            entry_q[1] <= '0;
        end else begin
            state <= state_nxt;
            if (push) begin
                entry_q[wr_ptr] <= '{rd: in_rd, data: wb_data};
                wr_ptr          <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
        end
    end

    // Occupancy transitions driven by push/pop.
    always_comb begin
        state_nxt = state;
        case (state)
            FIFO_EMPTY: if (push) state_nxt = FIFO_ONE;
            FIFO_ONE: begin
                if (push && !pop)      state_nxt = FIFO_TWO;
                else if (pop && !push) state_nxt = FIFO_EMPTY;
            end
            FIFO_TWO:   if (pop) state_nxt = FIFO_ONE;
            default:    state_nxt = FIFO_EMPTY;
        endcase
    end

    // Present the head entry on the write port, zeros when empty.
    always_comb begin
        head   = entry_q[rd_ptr];
        wr     = (state != FIFO_EMPTY);
        add_wr = wr ? head.rd   : '0;
        datain = wr ? head.data : '0;
    end

    // The younger entry sits just behind the tail; with one entry it is also the head.
    always_comb begin
        young   = entry_q[~wr_ptr];
        old     = entry_q[rd_ptr];
        young_v = (state != FIFO_EMPTY);
        old_v   = (state == FIFO_TWO);
    end

    function automatic logic [NBITS:0] fwd_lookup(
        input logic [AW-1:0] q,
        input wb_entry_t     y,
        input logic          y_v,
        input wb_entry_t     o,
        input logic          o_v
    );
        if (q == '0)                 return '0;
        else if (y_v && (y.rd == q)) return {1'b1, y.data};
        else if (o_v && (o.rd == q)) return {1'b1, o.data};
        else                         return '0;
    endfunction

    assign {fwd1_hit, fwd1_data} = fwd_lookup(q_rd1, young, young_v, old, old_v);
    assign {fwd2_hit, fwd2_data} = fwd_lookup(q_rd2, young, young_v, old, old_v);

endmodule

// File: tb/tb_wb_regfile_writer.sv
// Self-checking bench for wb_regfile_writer.
module tb_wb_regfile_writer;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  in_rd;
    logic [1:0]  in_src;
    logic [31:0] in_alu, in_mem, in_pc4;
    logic [2:0]  in_funct3;
    logic [1:0]  in_addr_lo;
    logic        rf_gnt;
    logic        wr;
    logic [4:0]  add_wr;
    logic [31:0] datain;
    logic [4:0]  q_rd1, q_rd2;
    logic        fwd1_hit, fwd2_hit;
    logic [31:0] fwd1_data, fwd2_data;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    wb_regfile_writer #(.NBITS(32), .NREGISTERS(32)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_rd(in_rd), .in_src(in_src),
        .in_alu(in_alu), .in_mem(in_mem), .in_pc4(in_pc4),
        .in_funct3(in_funct3), .in_addr_lo(in_addr_lo),
        .rf_gnt(rf_gnt), .wr(wr), .add_wr(add_wr), .datain(datain),
        .q_rd1(q_rd1), .q_rd2(q_rd2),
        .fwd1_hit(fwd1_hit), .fwd2_hit(fwd2_hit),
        .fwd1_data(fwd1_data), .fwd2_data(fwd2_data)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        in_valid = 0; in_rd = 0; in_src = 0; in_alu = 0; in_mem = 0; in_pc4 = 0;
        in_funct3 = 0; in_addr_lo = 0;
    endtask

    task automatic offer_alu(input logic [4:0] rd, input logic [31:0] d);
        in_valid = 1; in_rd = rd; in_src = 2'b00; in_alu = d;
    endtask

    // Reference load extraction from shift-and-mask arithmetic.
    function automatic logic [31:0] ref_load(input logic [31:0] m, input logic [2:0] f3,
                                             input logic [1:0] off);
        logic [31:0] b, h;
        b = (m >> (8 * off)) & 32'hFF;
        h = (m >> (16 * off[1])) & 32'hFFFF;
        case (f3)
            3'b000:  return b[7]  ? (b | 32'hFFFF_FF00) : b;
            3'b001:  return h[15] ? (h | 32'hFFFF_0000) : h;
            3'b100:  return b;
            3'b101:  return h;
            default: return m;
        endcase
    endfunction

    function automatic logic [31:0] ref_result(input logic [1:0] src, input logic [31:0] alu,
                                               input logic [31:0] mem, input logic [31:0] pc4,
                                               input logic [2:0] f3, input logic [1:0] off);
        if (src == 2'b01)      return ref_load(mem, f3, off);
        else if (src == 2'b10) return pc4;
        else                   return alu;
    endfunction

    typedef struct {
        logic [1:0]  src;
        logic [31:0] alu;
        logic [31:0] mem;
        logic [31:0] pc4;
        logic [2:0]  f3;
        logic [1:0]  off;
        logic [31:0] exp;
    } vec_t;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
    } pend_t;

    vec_t  vecs [12];
    pend_t mq[$];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0]  = '{2'b01, 32'h0, 32'h80FF7F01, 32'h0, 3'b000, 2'd3, 32'hFFFFFF80};
        vecs[1]  = '{2'b01, 32'h0, 32'h80FF7F01, 32'h0, 3'b100, 2'd1, 32'h0000007F};
        vecs[2]  = '{2'b01, 32'h0, 32'h80FF7F01, 32'h0, 3'b001, 2'd2, 32'hFFFF80FF};
        vecs[3]  = '{2'b01, 32'h0, 32'h80FF7F01, 32'h0, 3'b101, 2'd0, 32'h00007F01};
        vecs[4]  = '{2'b01, 32'h0, 32'h80FF7F01, 32'h0, 3'b010, 2'd2, 32'h80FF7F01};
        vecs[5]  = '{2'b01, 32'h0, 32'h80FF7F01, 32'h0, 3'b011, 2'd1, 32'h80FF7F01};
        vecs[6]  = '{2'b01, 32'h0, 32'h80FF7F01, 32'h0, 3'b000, 2'd2, 32'hFFFFFFFF};
        vecs[7]  = '{2'b01, 32'h0, 32'h80FF7F01, 32'h0, 3'b001, 2'd3, 32'hFFFF80FF};
        vecs[8]  = '{2'b01, 32'h0, 32'h80FF7F01, 32'h0, 3'b101, 2'd2, 32'h000080FF};
        vecs[9]  = '{2'b00, 32'hCAFEBABE, 32'h1, 32'h2, 3'b000, 2'd0, 32'hCAFEBABE};
        vecs[10] = '{2'b10, 32'h3, 32'h4, 32'h00001004, 3'b000, 2'd0, 32'h00001004};
        vecs[11] = '{2'b11, 32'h5A5A0F0F, 32'h6, 32'h7, 3'b001, 2'd0, 32'h5A5A0F0F};

        // Reset state
        rst = 1; rf_gnt = 0; q_rd1 = 5'd5; q_rd2 = 5'd6; idle();
        tick(); tick();
        chk("rst_in_ready", in_ready, 0);
        chk("rst_wr", wr, 0);
        chk("rst_add_wr", add_wr, 0);
        chk("rst_datain", datain, 0);
        chk("rst_fwd1", fwd1_hit, 0);
        rst = 0;
        tick();

        // Single ALU result with grant held
        rf_gnt = 1; offer_alu(5'd5, 32'h12345678);
        #1 chk("alu_ready", in_ready, 1);
        tick(); idle();
        chk("alu_wr", wr, 1);
        chk("alu_add", add_wr, 5);
        chk("alu_data", datain, 32'h12345678);
        tick();
        chk("alu_wr_drop", wr, 0);

        // Source select and load alignment table
        for (int i = 0; i < 12; i++) begin
            in_valid = 1; in_rd = 5'd9; in_src = vecs[i].src; in_alu = vecs[i].alu;
            in_mem = vecs[i].mem; in_pc4 = vecs[i].pc4;
            in_funct3 = vecs[i].f3; in_addr_lo = vecs[i].off;
            tick(); idle();
            chk($sformatf("vec%0d_data", i), datain, vecs[i].exp);
            chk($sformatf("vec%0d_add", i), add_wr, 9);
            tick();
        end

        // Fill with no grant, then drain in order; a full FIFO takes no new entry
        rf_gnt = 0;
        offer_alu(5'd1, 32'h87654321); tick();
        offer_alu(5'd2, 32'h11111111); tick();
        offer_alu(5'd4, 32'h44444444);
        #1;
        chk("full_ready", in_ready, 0);
        chk("full_wr", wr, 1);
        chk("full_add", add_wr, 1);
        chk("full_data", datain, 32'h87654321);
        rf_gnt = 1;
        tick(); idle();
        chk("drain1_add", add_wr, 2);
        chk("drain1_data", datain, 32'h11111111);
        chk("drain1_ready", in_ready, 1);
        tick();
        chk("drain2_wr", wr, 0);
        rf_gnt = 0;

        // Forwarding: younger of two matches wins
        offer_alu(5'd7, 32'hA); tick(); idle();
        q_rd1 = 5'd7;
        #1 chk("fwd_one_hit", fwd1_hit, 1);
        chk("fwd_one_data", fwd1_data, 32'hA);
        offer_alu(5'd7, 32'hB); tick(); idle();
        q_rd2 = 5'd0;
        #1;
        chk("fwd_two_hit", fwd1_hit, 1);
        chk("fwd_two_data", fwd1_data, 32'hB);
        chk("fwd_x0_hit", fwd2_hit, 0);
        chk("fwd_x0_data", fwd2_data, 0);
        q_rd2 = 5'd3;
        #1 chk("fwd_miss_hit", fwd2_hit, 0);
        rf_gnt = 1; q_rd1 = 5'd7;
        #1 chk("fwd_pop_data", fwd1_data, 32'hB);
        tick();
        chk("fwd_after_pop", fwd1_data, 32'hB);
        tick();
        chk("fwd_empty_hit", fwd1_hit, 0);

        // Write to x0 is consumed without enqueue
        offer_alu(5'd0, 32'hDEAD);
        #1 chk("x0_ready", in_ready, 1);
        tick(); idle();
        chk("x0_wr", wr, 0);
        chk("x0_ready_after", in_ready, 1);
        tick();
        chk("x0_wr2", wr, 0);

        // Asynchronous reset with two pending entries
        rf_gnt = 0;
        offer_alu(5'd10, 32'hAAAA0000); tick();
        offer_alu(5'd11, 32'hBBBB0000); tick(); idle();
        q_rd1 = 5'd10;
        #2 rst = 1;
        #1;
        chk("arst_wr", wr, 0);
        chk("arst_add", add_wr, 0);
        chk("arst_data", datain, 0);
        chk("arst_ready", in_ready, 0);
        chk("arst_fwd", fwd1_hit, 0);
        tick();
        chk("arst_ready_hold", in_ready, 0);
        rst = 0; rf_gnt = 1;
        #1;
        chk("arst_rel_ready", in_ready, 1);
        chk("arst_rel_wr", wr, 0);
        tick();
        chk("arst_no_stale", wr, 0);

        // Randomized traffic against a queue model
        mq.delete();
        for (int cyc = 0; cyc < 400; cyc++) begin
            logic        e_ready, e_wr, h1, h2;
            logic [4:0]  e_add;
            logic [31:0] e_data, d1, d2;
            in_valid   = 1'($urandom_range(0, 1));
            in_rd      = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 6));
            in_src     = 2'($urandom);
            in_alu     = $urandom;
            in_mem     = $urandom;
            in_pc4     = $urandom;
            in_funct3  = 3'($urandom);
            in_addr_lo = 2'($urandom);
            rf_gnt     = 1'($urandom_range(0, 1));
            q_rd1      = 5'($urandom_range(0, 6));
            q_rd2      = 5'($urandom_range(0, 6));
            #1;
            e_ready = (mq.size() < 2);
            e_wr    = (mq.size() != 0);
            e_add   = e_wr ? mq[0].rd   : 5'd0;
            e_data  = e_wr ? mq[0].data : 32'd0;
            h1 = 0; d1 = 0; h2 = 0; d2 = 0;
            for (int i = mq.size() - 1; i >= 0; i--) begin
                if (!h1 && q_rd1 != 0 && mq[i].rd == q_rd1) begin h1 = 1; d1 = mq[i].data; end
                if (!h2 && q_rd2 != 0 && mq[i].rd == q_rd2) begin h2 = 1; d2 = mq[i].data; end
            end
            chk("rnd_ready", in_ready, e_ready);
            chk("rnd_wr", wr, e_wr);
            chk("rnd_add", add_wr, e_add);
            chk("rnd_data", datain, e_data);
            chk("rnd_fwd1", {fwd1_hit, fwd1_data[30:0]} ^ {31'd0, fwd1_data[31]},
                {h1, d1[30:0]} ^ {31'd0, d1[31]});
            chk("rnd_fwd1_msb", fwd1_data[31], d1[31]);
            chk("rnd_fwd2_hit", fwd2_hit, h2);
            chk("rnd_fwd2_data", fwd2_data, d2);
            if (e_wr && rf_gnt) void'(mq.pop_front());
            if (in_valid && e_ready && in_rd != 0)
                mq.push_back('{in_rd, ref_result(in_src, in_alu, in_mem, in_pc4,
                                                 in_funct3, in_addr_lo)});
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
